// File: rtl/wb_data_ram_responder_pkg.sv
// Shared constants for the Wishbone data-RAM responder: bus geometry and
// the responder FSM encoding (also visible on the dbg_state output).
package wb_data_ram_responder_pkg;

    localparam int DATA_W = 32;
    localparam int LANES  = 4;
    localparam int LANE_W = 8;

    typedef enum logic [1:0] {
        RESP_IDLE = 2'd0,
        RESP_WAIT = 2'd1,
        RESP_ACK  = 2'd2,
        RESP_ERR  = 2'd3
    } resp_state_e;

endpackage

// File: rtl/wb_ram_bank.sv
// One byte lane of the data RAM: single port, synchronous write, registered
// read (read-before-write on a colliding access). Contents are never reset.
module wb_ram_bank #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [7:0]            wdata,
    output logic [7:0]            rdata
);

    logic [7:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/wb_data_ram_responder.sv
// Wishbone-classic slave data RAM with WAIT_CYCLES wait states, byte-lane
// writes and an error completion for out-of-window or empty-lane requests.
module wb_data_ram_responder
    import wb_data_ram_responder_pkg::*;
#(
    parameter int          ADDR_WIDTH  = 10,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [31:0] wb_adr_i,
    input  logic [3:0]  wb_sel_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic [1:0]  dbg_state
);

    localparam int         HI        = ADDR_WIDTH + 2;
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    // Handshake: a request is cyc & stb sampled on a rising edge while IDLE;
    // completion is exactly one cycle of ack (or err). While a request is
    // outstanding, stb/we/adr/sel/dat are ignored; only cyc is watched.
    resp_state_e           state;
    logic [3:0]            cnt;
    logic                  lat_we;
    logic [ADDR_WIDTH-1:0] lat_idx;
    logic [3:0]            lat_sel;
    logic [DATA_W-1:0]     lat_dat;

    logic                  req;
    logic                  in_window;
    logic                  enter_resp;
    logic                  cur_we;
    logic [ADDR_WIDTH-1:0] cur_idx;
    logic [3:0]            cur_sel;
    logic [DATA_W-1:0]     cur_dat;
    logic [LANES-1:0]      bank_we;
    logic [DATA_W-1:0]     rd_word;
    logic                  adr_unused;

    assign req        = wb_cyc_i & wb_stb_i;
    assign in_window  = (wb_adr_i[31:HI] == BASE_ADDR[31:HI]);
    assign adr_unused = ^wb_adr_i[1:0];
    assign dbg_state  = state;

    // With no wait states the RAM is accessed on the capture edge itself, so
    // the live bus fields feed the banks while IDLE.
    always_comb begin
        cur_we  = lat_we;
        cur_idx = lat_idx;
        cur_sel = lat_sel;
        cur_dat = lat_dat;
        if (state == RESP_IDLE) begin
            cur_we  = wb_we_i;
            cur_idx = wb_adr_i[HI-1:2];
            cur_sel = wb_sel_i;
            cur_dat = wb_dat_i;
        end
    end

    always_comb begin
        enter_resp = 1'b0;
        if (state == RESP_IDLE) begin
            enter_resp = req && in_window && (wb_sel_i != 4'b0) && (WAIT_CYCLES == 0);
        end else if (state == RESP_WAIT) begin
            enter_resp = wb_cyc_i && (cnt == 4'd0);
        end
    end

    assign bank_we = (enter_resp && cur_we) ? cur_sel : 4'b0;

    for (genvar b = 0; b < LANES; b++) begin : g_bank
        wb_ram_bank #(.ADDR_WIDTH(ADDR_WIDTH)) u_bank (
            .clk   (clk),
            .we    (bank_we[b]),
            .addr  (cur_idx),
            .wdata (cur_dat[LANE_W*b +: LANE_W]),
            .rdata (rd_word[LANE_W*b +: LANE_W])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= RESP_IDLE;
            cnt      <= 4'd0;
            lat_we   <= 1'b0;
            lat_idx  <= '0;
            lat_sel  <= 4'b0;
            lat_dat  <= '0;
            wb_ack_o <= 1'b0;
            wb_err_o <= 1'b0;
            wb_dat_o <= '0;
        end else begin
            wb_ack_o <= 1'b0;
            wb_err_o <= 1'b0;
            case (state)
                RESP_IDLE: begin
                    if (req) begin
                        lat_we  <= wb_we_i;
                        lat_idx <= wb_adr_i[HI-1:2];
                        lat_sel <= wb_sel_i;
                        lat_dat <= wb_dat_i;
                        if (!in_window || wb_sel_i == 4'b0) begin
                            state <= RESP_ERR;
                        end else if (WAIT_CYCLES == 0) begin
                            state <= RESP_ACK;
                        end else begin
                            state <= RESP_WAIT;
                            cnt   <= WAIT_LOAD;
                        end
                    end
                end
                RESP_WAIT: begin
                    if (!wb_cyc_i) begin
                        state <= RESP_IDLE;
                    end else if (cnt == 4'd0) begin
                        state <= RESP_ACK;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP_ACK: begin
                    wb_ack_o <= 1'b1;
                    wb_dat_o <= lat_we ? '0 : rd_word;
                    state    <= RESP_IDLE;
                end
                default: begin
                    wb_err_o <= 1'b1;
                    wb_dat_o <= '0;
                    state    <= RESP_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/wb_data_ram_responder.md
Name: wb_data_ram_responder

Overview:
- Wishbone-classic slave data memory: the responder end of the CPU data-bus protocol that the openmips core drives as initiator.
- Sits in the min SOPC between the core's data-bus master port and the bus fabric. It replaces the zero-latency data_ram with a handshaked RAM that has configurable wait states.
- Supports byte-lane writes and reports out-of-window accesses with an error cycle.

Parameters:
- ADDR_WIDTH, 10, word-address bits (memory depth = 2**ADDR_WIDTH 32-bit words).
- BASE_ADDR, 32'h0000_0000, byte base address of the window; must be aligned to 4*2**ADDR_WIDTH.
- WAIT_CYCLES, 1, extra wait cycles between request capture and ack (0..15).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- wb_cyc_i  in  1  bus cycle active.
- wb_stb_i  in  1  strobe / request valid.
- wb_we_i  in  1  1 = write, 0 = read.
- wb_adr_i  in  32  byte address; bits [1:0] ignored.
- wb_sel_i  in  4  byte-lane enables; bit3 = data[31:24] (big-endian lane order, matching bank3..bank0).
- wb_dat_i  in  32  write data.
- wb_dat_o  out  32  read data.
- wb_ack_o  out  1  successful completion, one-cycle pulse.
- wb_err_o  out  1  error completion, one-cycle pulse.

Behaviour:
- Reset (rst low, asynchronous):
  - wb_ack_o=0, wb_err_o=0, wb_dat_o=0.
  - FSM=IDLE, wait counter=0.
  - Memory contents are not cleared.
- FSM states are IDLE, WAIT, RESP, ERR.
- IDLE:
  - Holds when wb_cyc_i & wb_stb_i is low.
  - When wb_cyc_i & wb_stb_i is high at an edge, latch we/adr/sel/dat.
  - If wb_adr_i[31:ADDR_WIDTH+2] != BASE_ADDR[31:ADDR_WIDTH+2] or wb_sel_i==0, go to ERR.
  - Otherwise, if WAIT_CYCLES==0 go to RESP, else go to WAIT with counter=WAIT_CYCLES-1.
- WAIT:
  - Decrement the counter each cycle; at counter==0 go to RESP.
  - If wb_cyc_i drops, go to IDLE: abort, no write, no ack.
- RESP entry edge:
  - wb_ack_o rises.
  - Write: each selected byte lane of the latched word is written; unselected lanes are unchanged. wb_dat_o=0.
  - Read: wb_dat_o = full 32-bit word at the latched index, regardless of sel.
- RESP: ack stays high exactly one cycle, then the FSM returns to IDLE and ack/err clear. wb_dat_o holds its value until the next completion.
- ERR: wb_err_o high exactly one cycle, no memory access, wb_dat_o=0, then IDLE.
- Latency: request captured at edge N. Ack/err is high during the cycle after edge N+1+WAIT_CYCLES.
- A strobe still high during the ack/err cycle is not sampled. It is seen as a new request on the next IDLE edge, so the minimum request spacing is WAIT_CYCLES+2 cycles.
- Word index = latched adr[ADDR_WIDTH+1:2]. Addresses do not wrap outside the window; they always error.
- Input changes after capture are ignored until completion.
- Reset asserted mid-transaction: the FSM returns to IDLE immediately and no pending write is performed. Words already written are retained.

Decomposition:
- Shared package/defines file holds:
  - FSM state encoding: 2-bit constants RESP_IDLE, RESP_WAIT, RESP_ACK, RESP_ERR.
  - Bus width constants (32-bit data, 4 lanes).
- One natural sub-module: wb_ram_bank, a single-port byte-wide synchronous RAM (depth 2**ADDR_WIDTH, write enable, registered read). Instantiate four, one per lane.

Test Plan:
- Reset: hold rst=0 for 25 ns, release -> ack=0, err=0, dat_o=0 and FSM=IDLE throughout reset.
- Full write/read, WAIT_CYCLES=1:
  - Write adr 0x8, sel 4'hF, dat 0x1234_5678 -> ack high during the cycle after edge N+2.
  - Read adr 0x8 -> dat_o=0x1234_5678 with ack.
- Byte lanes:
  - Write 0xAABB_CCDD at adr 0x8 with sel 4'b0101 over the prior 0x1234_5678.
  - Read adr 0x8 -> 0x12BB_56DD.
- Out of window, BASE_ADDR=0, ADDR_WIDTH=10:
  - Read adr 0x0000_1000 -> err pulse one cycle, ack never set, dat_o=0.
  - sel=0 request -> err pulse one cycle.
- Abort: WAIT_CYCLES=3, write adr 0x4 dat 0xDEAD_BEEF, drop cyc after 1 cycle -> no ack; read adr 0x4 returns its old value.
- Back-to-back and reset mid-op:
  - stb held high continuously, WAIT_CYCLES=0 -> acks spaced exactly 2 cycles apart.
  - rst pulsed low during WAIT of a write -> ack never appears, target word unchanged.
